// File: rtl/efuse_pkg.sv
// Shared types and timing constants for the SISO32 eFuse controller.
// Window bounds are slot-cycle indices within one bit slot (inclusive).
package efuse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PROG = 2'd1,
    ST_READ = 2'd2,
    ST_DONE = 2'd3
  } efuse_state_e;

  localparam int unsigned NBITS_DEF    = 32;
  localparam int unsigned PGM_SLOT_DEF = 256;
  localparam int unsigned RD_SLOT_DEF  = 32;

  // program slot: SCLK wraps the PGM pulse with 4 cycles of margin each side
  localparam int unsigned PGM_SCLK_LO  = 4;
  localparam int unsigned PGM_SCLK_HI  = 251;
  localparam int unsigned PGM_PULSE_LO = 8;
  localparam int unsigned PGM_PULSE_HI = 247;

  // read slot: data is taken well after SCLK rises, before it falls
  localparam int unsigned RD_SCLK_LO   = 8;
  localparam int unsigned RD_SCLK_HI   = 23;
  localparam int unsigned RD_SAMPLE    = 20;

  function automatic logic in_window(input int unsigned v, input int unsigned lo,
                                     input int unsigned hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/efuse_slot_timer.sv
// Slot/bit counter pair for the eFuse sequencer. The slot counter runs
// 0..slot_len-1 and then advances the bit index (LSB first). The next-count
// outputs let the top register its pins in step with the counters.
module efuse_slot_timer
  import efuse_pkg::*;
#(
  parameter  int unsigned NBITS    = NBITS_DEF,
  parameter  int unsigned PGM_SLOT = PGM_SLOT_DEF,
  parameter  int unsigned RD_SLOT  = RD_SLOT_DEF,
  localparam int unsigned CW       = $clog2((PGM_SLOT > RD_SLOT) ? PGM_SLOT : RD_SLOT),
  localparam int unsigned BW       = $clog2(NBITS)
) (
  input  logic          clk_osc,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_en,
  input  logic          i_prog_mode,
  output logic [CW-1:0] o_slot,
  output logic [BW-1:0] o_bit,
  output logic [CW-1:0] o_slot_nxt,
  output logic [BW-1:0] o_bit_nxt,
  output logic          o_last_slot,
  output logic          o_last_bit
);

  logic [CW-1:0] r_slot;
  logic [BW-1:0] r_bit;
  logic [CW-1:0] w_slot_end;
  logic [CW-1:0] w_slot_nxt;
  logic [BW-1:0] w_bit_nxt;

  assign w_slot_end  = i_prog_mode ? CW'(PGM_SLOT - 1) : CW'(RD_SLOT - 1);
  assign o_last_slot = (r_slot == w_slot_end);
  assign o_last_bit  = (r_bit == BW'(NBITS - 1));

  // next counter values: load clears, enable advances slot then bit
  always_comb begin
    w_slot_nxt = r_slot;
    w_bit_nxt  = r_bit;
    if (i_load) begin
      w_slot_nxt = '0;
      w_bit_nxt  = '0;
    end else if (i_en) begin
      if (o_last_slot) begin
        w_slot_nxt = '0;
        w_bit_nxt  = o_last_bit ? '0 : r_bit + BW'(1);
      end else begin
        w_slot_nxt = r_slot + CW'(1);
      end
    end
  end

  // counter registers
  always_ff @(posedge clk_osc or posedge rst) begin
    if (rst) begin
      r_slot <= '0;
      r_bit  <= '0;
    end else begin
      r_slot <= w_slot_nxt;
      r_bit  <= w_bit_nxt;
    end
  end

  assign o_slot     = r_slot;
  assign o_bit      = r_bit;
  assign o_slot_nxt = w_slot_nxt;
  assign o_bit_nxt  = w_bit_nxt;

endmodule

// File: rtl/efuse_siso32_ctrl.sv
// Sequencer for a 32-bit serial-in/serial-out eFuse macro.
// Build option: define EFUSE_PROG_EN to include the program path; without it
// the block is read-only (prog_start ignored, PGM/RW tied low).
// Pins are registered from the next state/count so they line up with the
// state they belong to: CS is high for exactly the PROG/READ cycles.
module efuse_siso32_ctrl
  import efuse_pkg::*;
#(
  parameter int unsigned NBITS    = NBITS_DEF,
  parameter int unsigned PGM_SLOT = PGM_SLOT_DEF,
  parameter int unsigned RD_SLOT  = RD_SLOT_DEF
) (
  input  logic             clk_osc,
  input  logic             rst,
  input  logic             read_start,
  output logic             read_ack,
  output logic [NBITS-1:0] dout,
  output logic             dout_valid,
  input  logic [NBITS-1:0] efuse_din,
  input  logic             prog_start,
  output logic             prog_ack,
  output logic             EFUSE_CS,
  output logic             EFUSE_PGM,
  output logic             EFUSE_SCLK,
  output logic             EFUSE_RW,
  input  logic             EFUSE_DOUT
);

  localparam int unsigned CW = $clog2((PGM_SLOT > RD_SLOT) ? PGM_SLOT : RD_SLOT);
  localparam int unsigned BW = $clog2(NBITS);

  efuse_state_e     r_state;
  efuse_state_e     w_state_nxt;
  logic             w_load;
  logic             w_en;
  logic             w_read_accept;
  logic             w_done_read;
  logic             w_sample;
  logic             w_cs_nxt;
  logic             w_sclk_nxt;
  logic [31:0]      w_slot_nxt_u;

  logic [CW-1:0]    w_slot;
  logic [BW-1:0]    w_bit;
  logic [CW-1:0]    w_slot_nxt;
  logic [BW-1:0]    w_bit_nxt;
  logic             w_last_slot;
  logic             w_last_bit;

  logic             r_read_ack;
  logic             r_dout_valid;
  logic [NBITS-1:0] r_dout;
  logic [NBITS-1:0] r_rdata;
  logic             r_cs;
  logic             r_sclk;

`ifdef EFUSE_PROG_EN
  logic             w_prog_accept;
`endif

  efuse_slot_timer #(
    .NBITS    (NBITS),
    .PGM_SLOT (PGM_SLOT),
    .RD_SLOT  (RD_SLOT)
  ) u_timer (
    .clk_osc     (clk_osc),
    .rst         (rst),
    .i_load      (w_load),
    .i_en        (w_en),
    .i_prog_mode (r_state == ST_PROG),
    .o_slot      (w_slot),
    .o_bit       (w_bit),
    .o_slot_nxt  (w_slot_nxt),
    .o_bit_nxt   (w_bit_nxt),
    .o_last_slot (w_last_slot),
    .o_last_bit  (w_last_bit)
  );

  // next-state logic; read has priority over program when both are pending
  always_comb begin
    w_state_nxt   = r_state;
    w_load        = 1'b0;
    w_en          = 1'b0;
    w_read_accept = 1'b0;
`ifdef EFUSE_PROG_EN
    w_prog_accept = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (read_start) begin
          w_state_nxt   = ST_READ;
          w_load        = 1'b1;
          w_read_accept = 1'b1;
        end
`ifdef EFUSE_PROG_EN
        else if (prog_start) begin
          w_state_nxt   = ST_PROG;
          w_load        = 1'b1;
          w_prog_accept = 1'b1;
        end
`endif
      end
`ifdef EFUSE_PROG_EN
      ST_PROG: begin
        w_en = 1'b1;
        if (w_last_slot && w_last_bit) w_state_nxt = ST_DONE;
      end
`endif
      ST_READ: begin
        w_en = 1'b1;
        if (w_last_slot && w_last_bit) w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_slot_nxt_u = 32'(w_slot_nxt);
  assign w_cs_nxt     = (w_state_nxt == ST_READ) || (w_state_nxt == ST_PROG);
  assign w_sclk_nxt   = ((w_state_nxt == ST_READ) &&
                         in_window(w_slot_nxt_u, RD_SCLK_LO, RD_SCLK_HI)) ||
                        ((w_state_nxt == ST_PROG) &&
                         in_window(w_slot_nxt_u, PGM_SCLK_LO, PGM_SCLK_HI));
  assign w_done_read  = (r_state == ST_READ) && (w_state_nxt == ST_DONE);
  assign w_sample     = (r_state == ST_READ) && (w_slot == CW'(RD_SAMPLE));

  // state register
  always_ff @(posedge clk_osc or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // registered handshake, read data and common pins
  always_ff @(posedge clk_osc or posedge rst) begin
    if (rst) begin
      r_read_ack   <= 1'b0;
      r_dout_valid <= 1'b0;
      r_dout       <= '0;
      r_rdata      <= '0;
      r_cs         <= 1'b0;
      r_sclk       <= 1'b0;
    end else begin
      r_read_ack   <= w_read_accept;
      r_dout_valid <= w_done_read;
      r_cs         <= w_cs_nxt;
      r_sclk       <= w_sclk_nxt;
      if (w_sample)    r_rdata[w_bit] <= EFUSE_DOUT;
      if (w_done_read) r_dout <= r_rdata;
    end
  end

  assign read_ack   = r_read_ack;
  assign dout_valid = r_dout_valid;
  assign dout       = r_dout;
  assign EFUSE_CS   = r_cs;
  assign EFUSE_SCLK = r_sclk;

`ifdef EFUSE_PROG_EN
  logic [NBITS-1:0] r_wdata;
  logic             r_prog_ack;
  logic             r_pgm;
  logic             r_rw;
  logic             w_pgm_nxt;

  // PGM window sits strictly inside the SCLK window, so PGM never leads SCLK
  assign w_pgm_nxt = (w_state_nxt == ST_PROG) &&
                     in_window(w_slot_nxt_u, PGM_PULSE_LO, PGM_PULSE_HI) &&
                     r_wdata[w_bit_nxt];

  // program word capture and program-only pins
  always_ff @(posedge clk_osc or posedge rst) begin
    if (rst) begin
      r_wdata    <= '0;
      r_prog_ack <= 1'b0;
      r_pgm      <= 1'b0;
      r_rw       <= 1'b0;
    end else begin
      if (w_prog_accept) r_wdata <= efuse_din;
      r_prog_ack <= w_prog_accept;
      r_pgm      <= w_pgm_nxt;
      r_rw       <= (w_state_nxt == ST_PROG);
    end
  end

  assign prog_ack  = r_prog_ack;
  assign EFUSE_PGM = r_pgm;
  assign EFUSE_RW  = r_rw;
`else
  logic w_unused_prog;
  assign w_unused_prog = ^{efuse_din, prog_start};

  assign prog_ack  = 1'b0;
  assign EFUSE_PGM = 1'b0;
  assign EFUSE_RW  = 1'b0;
`endif

endmodule

// File: tb/tb_efuse_siso32_ctrl.sv
// Directed bench for efuse_siso32_ctrl with a behavioural fuse array model.
// Program-path steps are included when EFUSE_PROG_EN is defined.
`timescale 1ns/1ps
module tb_efuse_siso32_ctrl;

  logic        clk_osc = 1'b0;
  logic        rst;
  logic        read_start;
  logic        read_ack;
  logic [31:0] dout;
  logic        dout_valid;
  logic [31:0] efuse_din;
  logic        prog_start;
  logic        prog_ack;
  logic        EFUSE_CS;
  logic        EFUSE_PGM;
  logic        EFUSE_SCLK;
  logic        EFUSE_RW;
  logic        EFUSE_DOUT;

  int n_checks = 0;
  int n_errors = 0;

  always #20 clk_osc = ~clk_osc;

  efuse_siso32_ctrl dut (
    .clk_osc    (clk_osc),
    .rst        (rst),
    .read_start (read_start),
    .read_ack   (read_ack),
    .dout       (dout),
    .dout_valid (dout_valid),
    .efuse_din  (efuse_din),
    .prog_start (prog_start),
    .prog_ack   (prog_ack),
    .EFUSE_CS   (EFUSE_CS),
    .EFUSE_PGM  (EFUSE_PGM),
    .EFUSE_SCLK (EFUSE_SCLK),
    .EFUSE_RW   (EFUSE_RW),
    .EFUSE_DOUT (EFUSE_DOUT)
  );

  // fuse macro model: bit index = SCLK pulses seen since CS rose
  logic [31:0] fuse_model;
  int          sclk_cnt = 0;
  logic [4:0]  cur_idx = 5'd0;
  logic [4:0]  rise_idx = 5'd0;

  always @(posedge EFUSE_CS) sclk_cnt = 0;
  always @(posedge EFUSE_SCLK) begin
    cur_idx = 5'(sclk_cnt);
    sclk_cnt++;
  end
  always @(posedge EFUSE_PGM) begin
    rise_idx = cur_idx;
    if (EFUSE_CS && EFUSE_RW && EFUSE_SCLK) fuse_model[cur_idx] = 1'b1;
  end
  assign EFUSE_DOUT = (EFUSE_CS && !EFUSE_RW) ? fuse_model[cur_idx] : 1'b0;

  // pin activity counters
  int   cs_cyc = 0, sclk_cyc = 0, pgm_cyc = 0, rw_cyc = 0, pgm_bad = 0, pgm_rise = 0;
  logic pgm_d = 1'b0;
  always @(negedge clk_osc) begin
    if (EFUSE_CS)   cs_cyc++;
    if (EFUSE_SCLK) sclk_cyc++;
    if (EFUSE_PGM)  pgm_cyc++;
    if (EFUSE_RW)   rw_cyc++;
    if (EFUSE_PGM && (!EFUSE_SCLK || !EFUSE_CS || !EFUSE_RW)) pgm_bad++;
    if (EFUSE_PGM && !pgm_d) pgm_rise++;
    pgm_d = EFUSE_PGM;
  end

  int cs0, sclk0, pgm0, rw0, bad0, rise0;
  task automatic snap();
    cs0 = cs_cyc; sclk0 = sclk_cyc; pgm0 = pgm_cyc;
    rw0 = rw_cyc; bad0 = pgm_bad; rise0 = pgm_rise;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // one request phase; k counts negedges after the request was raised
  int          rack_k, rack_n, pack_k, pack_n, val_k, val_n;
  logic [31:0] val_data;
  task automatic run_op(input bit do_rd, input bit do_pr, input logic [31:0] wd,
                        input int hold_pr, input int ncyc);
    rack_k = -1; rack_n = 0; pack_k = -1; pack_n = 0; val_k = -1; val_n = 0;
    val_data = 32'hx;
    efuse_din = wd;
    if (do_rd) read_start = 1'b1;
    if (do_pr) prog_start = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk_osc);
      if (read_ack) begin
        rack_n++;
        if (rack_k < 0) rack_k = k;
        read_start = 1'b0;
      end
      if (prog_ack) begin
        pack_n++;
        if (pack_k < 0) pack_k = k;
        if (hold_pr == 0) prog_start = 1'b0;
      end
      if (hold_pr > 0 && k >= hold_pr) prog_start = 1'b0;
      if (dout_valid) begin
        val_n++;
        val_k = k;
        val_data = dout;
      end
    end
    read_start = 1'b0;
    prog_start = 1'b0;
  endtask

  task automatic check_read(input string t, input logic [31:0] exp);
    chk({t, "_ack_cycle"},   64'(rack_k), 64'd1);
    chk({t, "_ack_count"},   64'(rack_n), 64'd1);
    chk({t, "_valid_cycle"}, 64'(val_k), 64'd1025);
    chk({t, "_valid_count"}, 64'(val_n), 64'd1);
    chk({t, "_data"},        64'(val_data), 64'(exp));
    chk({t, "_dout_hold"},   64'(dout), 64'(exp));
    chk({t, "_cs_cycles"},   64'(cs_cyc - cs0), 64'd1024);
    chk({t, "_sclk_cycles"}, 64'(sclk_cyc - sclk0), 64'd512);
    chk({t, "_rw_cycles"},   64'(rw_cyc - rw0), 64'd0);
  endtask

`ifdef EFUSE_PROG_EN
  task automatic check_prog(input string t, input logic [31:0] word, input logic [31:0] old_dout);
    chk({t, "_ack_cycle"},   64'(pack_k), 64'd1);
    chk({t, "_ack_count"},   64'(pack_n), 64'd1);
    chk({t, "_cs_cycles"},   64'(cs_cyc - cs0), 64'd8192);
    chk({t, "_rw_cycles"},   64'(rw_cyc - rw0), 64'd8192);
    chk({t, "_sclk_cycles"}, 64'(sclk_cyc - sclk0), 64'd7936);
    chk({t, "_pgm_cycles"},  64'(pgm_cyc - pgm0), 64'($countones(word) * 240));
    chk({t, "_pgm_outside"}, 64'(pgm_bad - bad0), 64'd0);
    chk({t, "_no_valid"},    64'(val_n), 64'd0);
    chk({t, "_dout_kept"},   64'(dout), 64'(old_dout));
  endtask
`endif

  initial begin
    rst = 1'b1; read_start = 1'b0; prog_start = 1'b0; efuse_din = '0;
    fuse_model = '0;
    repeat (3) @(negedge clk_osc);
    chk("rst_cs",         64'(EFUSE_CS), 64'd0);
    chk("rst_pgm",        64'(EFUSE_PGM), 64'd0);
    chk("rst_sclk",       64'(EFUSE_SCLK), 64'd0);
    chk("rst_rw",         64'(EFUSE_RW), 64'd0);
    chk("rst_read_ack",   64'(read_ack), 64'd0);
    chk("rst_prog_ack",   64'(prog_ack), 64'd0);
    chk("rst_dout_valid", 64'(dout_valid), 64'd0);
    chk("rst_dout",       64'(dout), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk_osc);

    // unprogrammed fuse reads back zero
    snap();
    run_op(1'b1, 1'b0, 32'h0, 0, 1100);
    check_read("rd_blank", 32'h0000_0000);

`ifdef EFUSE_PROG_EN
    // program with prog_start held 10 cycles, then read back
    snap();
    run_op(1'b0, 1'b1, 32'hABCD_EF01, 10, 8300);
    check_prog("pg_abcd", 32'hABCD_EF01, 32'h0000_0000);
    chk("pg_abcd_model", 64'(fuse_model), 64'h0000_0000_ABCD_EF01);
    snap();
    run_op(1'b1, 1'b0, 32'h0, 0, 1100);
    check_read("rd_abcd", 32'hABCD_EF01);

    // single bit: one 240-cycle pulse in slot 0
    snap();
    run_op(1'b0, 1'b1, 32'h0000_0001, 0, 8300);
    check_prog("pg_one", 32'h0000_0001, 32'hABCD_EF01);
    chk("pg_one_rises",   64'(pgm_rise - rise0), 64'd1);
    chk("pg_one_rise_bit", 64'(rise_idx), 64'd0);

    // all zero: PGM never rises
    snap();
    run_op(1'b0, 1'b1, 32'h0000_0000, 0, 8300);
    check_prog("pg_zero", 32'h0000_0000, 32'hABCD_EF01);
    chk("pg_zero_rises", 64'(pgm_rise - rise0), 64'd0);
`else
    // read-only build: a program request is never acknowledged
    snap();
    run_op(1'b0, 1'b1, 32'hABCD_EF01, 10, 40);
    chk("ro_prog_ack",   64'(pack_n), 64'd0);
    chk("ro_prog_cs",    64'(cs_cyc - cs0), 64'd0);
    chk("ro_prog_pgm",   64'(pgm_cyc - pgm0), 64'd0);
    fuse_model = 32'hABCD_EF01;
    snap();
    run_op(1'b1, 1'b0, 32'h0, 0, 1100);
    check_read("rd_abcd", 32'hABCD_EF01);
`endif

    // simultaneous requests: read first, program only after DONE
    fuse_model = 32'h0F0F_3C3C;
    snap();
`ifdef EFUSE_PROG_EN
    run_op(1'b1, 1'b1, 32'h0000_0000, 0, 9300);
    chk("sim_prog_ack_cycle", 64'(pack_k), 64'd1027);
    chk("sim_prog_ack_count", 64'(pack_n), 64'd1);
    chk("sim_cs_cycles",      64'(cs_cyc - cs0), 64'd9216);
`else
    run_op(1'b1, 1'b1, 32'h0000_0000, 0, 1200);
    chk("sim_prog_ack_count", 64'(pack_n), 64'd0);
    chk("sim_cs_cycles",      64'(cs_cyc - cs0), 64'd1024);
`endif
    chk("sim_read_ack_cycle", 64'(rack_k), 64'd1);
    chk("sim_valid_cycle",    64'(val_k), 64'd1025);
    chk("sim_valid_count",    64'(val_n), 64'd1);
    chk("sim_data",           64'(val_data), 64'h0000_0000_0F0F_3C3C);

    // reset in the middle of an operation drops every pin at once
`ifdef EFUSE_PROG_EN
    run_op(1'b0, 1'b1, 32'hFFFF_FFFF, 0, 3000);
    chk("mid_pgm_before", 64'(EFUSE_PGM), 64'd1);
`else
    run_op(1'b1, 1'b0, 32'h0, 0, 500);
`endif
    chk("mid_cs_before",   64'(EFUSE_CS), 64'd1);
    chk("mid_sclk_before", 64'(EFUSE_SCLK), 64'd1);
    #3 rst = 1'b1;
    #1;
    chk("mid_cs_after",    64'(EFUSE_CS), 64'd0);
    chk("mid_pgm_after",   64'(EFUSE_PGM), 64'd0);
    chk("mid_sclk_after",  64'(EFUSE_SCLK), 64'd0);
    chk("mid_rw_after",    64'(EFUSE_RW), 64'd0);
    chk("mid_dout_after",  64'(dout), 64'd0);
    repeat (2) @(negedge clk_osc);
    rst = 1'b0;
    repeat (2) @(negedge clk_osc);

    fuse_model = 32'h1234_5678;
    snap();
    run_op(1'b1, 1'b0, 32'h0, 0, 1100);
    check_read("rd_post_rst", 32'h1234_5678);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
